// File: rtl/fpu_pkg.sv
// Shared constants and payload layouts for the fpu issue controller.
// Tags are appended by the users of these types because the tag width is a parameter.
package fpu_pkg;

  localparam int FP_W = 32;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int CMD_CORE_W = 2 * FP_W + 2;
  localparam int RES_CORE_W = FP_W + 1;

  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
    logic [1:0]      op;
  } cmd_core_t;

  typedef struct packed {
    logic [FP_W-1:0] data;
    logic            err;
  } res_core_t;

  // The fpu has no divider, so DIV is flagged and its result forced to zero.
  function automatic logic op_unsupported(input logic [1:0] op);
    return op == OP_DIV;
  endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// Show-ahead synchronous FIFO with full/empty flags and async active-high reset.
// Pushes while full and pops while empty are ignored.
module fpu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue stage for a 1-cycle fpu with no stall: buffers commands, drives the fpu,
// and returns tagged results in order, with credits sized to the result FIFO.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [FP_W-1:0]  cmd_a,
  input  logic [FP_W-1:0]  cmd_b,
  input  logic [1:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [FP_W-1:0]  fpu_a,
  output logic [FP_W-1:0]  fpu_b,
  output logic [1:0]       fpu_opcode,
  input  logic [FP_W-1:0]  fpu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [FP_W-1:0]  res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err,
  output logic             busy
);

  localparam int CMD_W = CMD_CORE_W + TAG_W;
  localparam int RES_W = RES_CORE_W + TAG_W;
  localparam int CRD_W = $clog2(RES_DEPTH + 1);
  localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(RES_DEPTH);
  localparam logic [CRD_W-1:0] CRD_ONE = CRD_W'(1);

  logic             w_cmd_full;
  logic             w_cmd_empty;
  logic             w_cmd_push;
  logic [CMD_W-1:0] w_cmd_wdata;
  logic [CMD_W-1:0] w_cmd_rdata;
  cmd_core_t        w_cmd_head;
  logic [TAG_W-1:0] w_cmd_head_tag;

  logic             w_res_full;
  logic             w_res_empty;
  logic             w_res_pop;
  res_core_t        w_res_core_in;
  logic [RES_W-1:0] w_res_wdata;
  logic [RES_W-1:0] w_res_rdata;
  res_core_t        w_res_head;
  logic [TAG_W-1:0] w_res_head_tag;

  logic             w_issue;
  logic [CRD_W-1:0] r_credits;

  logic [FP_W-1:0]  r_fpu_a;
  logic [FP_W-1:0]  r_fpu_b;
  logic [1:0]       r_fpu_op;
  logic             r_s1_v;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s1_err;
  logic             r_s2_v;
  logic [TAG_W-1:0] r_s2_tag;
  logic             r_s2_err;

  // No bypass: a full FIFO refuses even when its head pops this cycle.
  assign cmd_ready   = ~rst & ~w_cmd_full;
  assign w_cmd_push  = cmd_valid & cmd_ready;
  assign w_cmd_wdata = {cmd_tag, cmd_a, cmd_b, cmd_op};
  assign {w_cmd_head_tag, w_cmd_head} = w_cmd_rdata;

  fpu_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_cmd_push),
    .i_wdata (w_cmd_wdata),
    .i_pop   (w_issue),
    .o_rdata (w_cmd_rdata),
    .o_full  (w_cmd_full),
    .o_empty (w_cmd_empty)
  );

  // A credit reserves a result FIFO slot, so every issued op has somewhere to land.
  assign w_issue = ~w_cmd_empty && (r_credits != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fpu_a  <= '0;
      r_fpu_b  <= '0;
      r_fpu_op <= OP_ADD;
      r_s1_v   <= 1'b0;
      r_s1_tag <= '0;
      r_s1_err <= 1'b0;
      r_s2_v   <= 1'b0;
      r_s2_tag <= '0;
      r_s2_err <= 1'b0;
    end else begin
      r_s1_v   <= w_issue;
      r_s2_v   <= r_s1_v;
      r_s2_tag <= r_s1_tag;
      r_s2_err <= r_s1_err;
      if (w_issue) begin
        r_fpu_a  <= w_cmd_head.a;
        r_fpu_b  <= w_cmd_head.b;
        r_fpu_op <= w_cmd_head.op;
        r_s1_tag <= w_cmd_head_tag;
        r_s1_err <= op_unsupported(w_cmd_head.op);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credits <= CRD_MAX;
    end else begin
      case ({w_issue, w_res_pop})
        2'b10:   r_credits <= r_credits - CRD_ONE;
        2'b01:   r_credits <= r_credits + CRD_ONE;
        default: r_credits <= r_credits;
      endcase
    end
  end

  assign fpu_a      = r_fpu_a;
  assign fpu_b      = r_fpu_b;
  assign fpu_opcode = r_fpu_op;

  assign w_res_core_in.data = r_s2_err ? '0 : fpu_out;
  assign w_res_core_in.err  = r_s2_err;
  assign w_res_wdata        = {r_s2_tag, w_res_core_in};

  fpu_sync_fifo #(
    .WIDTH (RES_W),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (r_s2_v),
    .i_wdata (w_res_wdata),
    .i_pop   (w_res_pop),
    .o_rdata (w_res_rdata),
    .o_full  (w_res_full),
    .o_empty (w_res_empty)
  );

  assign {w_res_head_tag, w_res_head} = w_res_rdata;
  assign res_valid = ~w_res_empty;
  assign w_res_pop = res_valid & res_ready;
  assign res_data  = res_valid ? w_res_head.data : '0;
  assign res_tag   = res_valid ? w_res_head_tag  : '0;
  assign res_err   = res_valid ? w_res_head.err  : 1'b0;

  // Credits already prevent overflow; full only matters to the FIFO's own guard.
  assign busy = ~w_cmd_empty | r_s1_v | r_s2_v | ~w_res_empty | (w_res_full & 1'b0);

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl with a behavioural 1-cycle fpu stand-in; directed table,
// corner sequences, then randomized traffic against a queue-based reference model.
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  localparam int CMD_DEPTH = 4;
  localparam int RES_DEPTH = 4;
  localparam int TAG_W     = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_a;
  logic [31:0]      cmd_b;
  logic [1:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;
  logic [31:0]      fpu_a;
  logic [31:0]      fpu_b;
  logic [1:0]       fpu_opcode;
  logic [31:0]      fpu_out;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_err;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic             err;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } res_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp_data;
    logic [TAG_W-1:0] exp_tag;
    logic             exp_err;
  } vec_t;

  res_t exp_q[$];
  vec_t tbl[8];

  always #5 clk = ~clk;

  fpu_issue_ctrl #(
    .CMD_DEPTH (CMD_DEPTH),
    .RES_DEPTH (RES_DEPTH),
    .TAG_W     (TAG_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .cmd_tag    (cmd_tag),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_opcode (fpu_opcode),
    .fpu_out    (fpu_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_tag    (res_tag),
    .res_err    (res_err),
    .busy       (busy)
  );

  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:0] == 31'd0) d = {x[31], 63'd0};
    else d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Exact for the small-integer operands used here; DIV yields junk on purpose.
  function automatic logic [31:0] fp_calc(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    case (op)
      2'b00:   return r2sp(sp2r(a) + sp2r(b));
      2'b01:   return r2sp(sp2r(a) - sp2r(b));
      2'b10:   return r2sp(sp2r(a) * sp2r(b));
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic res_t model_res(input logic [31:0] a, input logic [31:0] b,
                                     input logic [1:0] op, input logic [TAG_W-1:0] tag);
    res_t r;
    r.err  = (op == 2'b11);
    r.tag  = tag;
    r.data = r.err ? 32'd0 : fp_calc(a, b, op);
    return r;
  endfunction

  // fpu stand-in: registered, unreset, one-cycle latency.
  always @(posedge clk) fpu_out <= fp_calc(fpu_a, fpu_b, fpu_opcode);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag);
    int w = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
    while (!cmd_ready && w < 20) begin step(); w++; end
    if (!cmd_ready) chk("send_timeout", 64'(cmd_ready), 64'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    while (!res_valid && lat < 20) begin step(); lat++; end
  endtask

  initial begin
    int lat, acc, issues, got, n_acc, n_res, cyc;
    logic hold_prev, seen;
    logic [63:0] prev_payload;
    res_t e;

    tbl[0] = '{OP_ADD, 32'h3F800000, 32'h40000000, 4'd3,  32'h40400000, 4'd3,  1'b0};
    tbl[1] = '{OP_DIV, 32'h40400000, 32'h3F800000, 4'd7,  32'h00000000, 4'd7,  1'b1};
    tbl[2] = '{OP_ADD, 32'h3F800000, 32'h40000000, 4'd5,  32'h40400000, 4'd5,  1'b0};
    tbl[3] = '{OP_SUB, 32'h40400000, 32'h3F800000, 4'd1,  32'h40000000, 4'd1,  1'b0};
    tbl[4] = '{OP_MUL, 32'h40000000, 32'h40400000, 4'd2,  32'h40C00000, 4'd2,  1'b0};
    tbl[5] = '{OP_SUB, 32'h3F800000, 32'h40400000, 4'd15, 32'hC0000000, 4'd15, 1'b0};
    tbl[6] = '{OP_MUL, 32'h40400000, 32'h40400000, 4'd9,  32'h41100000, 4'd9,  1'b0};
    tbl[7] = '{OP_DIV, 32'h00000000, 32'h00000000, 4'd12, 32'h00000000, 4'd12, 1'b1};

    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_payload", 64'({res_err, res_tag, res_data}), 64'd0);
    chk("rst_fpu", 64'({fpu_opcode, fpu_a}) | 64'(fpu_b), 64'd0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", 64'(cmd_ready), 64'd1);

    // Directed table: single ops on idle queues, latency and idle zeroing.
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag);
      wait_res(lat);
      chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'd3);
      chk($sformatf("tbl%0d_data", i), 64'(res_data), 64'(tbl[i].exp_data));
      chk($sformatf("tbl%0d_tag", i), 64'(res_tag), 64'(tbl[i].exp_tag));
      chk($sformatf("tbl%0d_err", i), 64'(res_err), 64'(tbl[i].exp_err));
      step();
      chk($sformatf("tbl%0d_idle", i), 64'({res_valid, res_err, res_tag, res_data}), 64'd0);
    end

    // Back-to-back SUB then MUL: results on consecutive cycles.
    cmd_valid = 1'b1; cmd_op = OP_SUB; cmd_a = 32'h40400000; cmd_b = 32'h3F800000; cmd_tag = 4'd1;
    step();
    cmd_op = OP_MUL; cmd_a = 32'h40000000; cmd_b = 32'h40400000; cmd_tag = 4'd2;
    step();
    cmd_valid = 1'b0;
    wait_res(lat);
    chk("b2b_latency", 64'(lat), 64'd2);
    chk("b2b_first", 64'({res_tag, res_data}), 64'({4'd1, 32'h40000000}));
    step();
    chk("b2b_second_valid", 64'(res_valid), 64'd1);
    chk("b2b_second", 64'({res_tag, res_data}), 64'({4'd2, 32'h40C00000}));
    step();

    // Backpressure: credits cap issue at RES_DEPTH, cmd FIFO fills behind.
    res_ready = 1'b0; acc = 0; issues = 0;
    for (int c = 0; c < 20; c++) begin
      cmd_valid = (acc < 10);
      cmd_op = OP_ADD; cmd_a = r2sp(real'(acc)); cmd_b = 32'h3F800000; cmd_tag = TAG_W'(acc);
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back(model_res(cmd_a, cmd_b, cmd_op, cmd_tag));
        acc++;
      end
      step();
      if (dut.r_s1_v) issues++;
    end
    chk("bp_accepts", 64'(acc), 64'(RES_DEPTH + CMD_DEPTH));
    chk("bp_issues", 64'(issues), 64'(RES_DEPTH));
    chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b0; res_ready = 1'b1; got = 0;
    for (int c = 0; c < 40; c++) begin
      if (res_valid) begin
        if (exp_q.size() == 0) chk("bp_extra_result", 64'(res_tag), 64'hFFFF);
        else begin
          e = exp_q.pop_front();
          chk("bp_result", 64'({res_err, res_tag, res_data}), 64'(e));
        end
        got++;
      end
      step();
    end
    chk("bp_count", 64'(got), 64'(RES_DEPTH + CMD_DEPTH));
    chk("bp_busy_end", 64'(busy), 64'd0);
    exp_q.delete();

    // Reset with three ops in flight: nothing comes back for them.
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_a = 32'h3F800000; cmd_b = 32'h3F800000;
      cmd_tag = TAG_W'(i + 1);
      step();
    end
    cmd_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_cmd_ready_after", 64'(cmd_ready), 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (res_valid) seen = 1'b1;
      step();
    end
    chk("midrst_no_result", 64'(seen), 64'd0);
    send(OP_ADD, 32'h3F800000, 32'h40000000, 4'd4);
    wait_res(lat);
    chk("midrst_new_add", 64'({res_valid, res_tag, res_data}), 64'({1'b1, 4'd4, 32'h40400000}));
    step();

    // Random traffic against the queue model.
    n_acc = 0; n_res = 0; cyc = 0; hold_prev = 1'b0; prev_payload = '0;
    while ((n_acc < 1000 || n_res < 1000) && cyc < 20000) begin
      cmd_valid = (n_acc < 1000) && ($urandom_range(0, 3) != 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_a     = r2sp(real'($urandom_range(0, 1000)));
      cmd_b     = r2sp(real'($urandom_range(0, 1000)));
      cmd_tag   = TAG_W'($urandom);
      res_ready = ($urandom_range(0, 2) != 0);
      if (hold_prev) begin
        chk("rnd_hold_valid", 64'(res_valid), 64'd1);
        chk("rnd_hold_payload", 64'({res_err, res_tag, res_data}), prev_payload);
      end
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back(model_res(cmd_a, cmd_b, cmd_op, cmd_tag));
        n_acc++;
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) chk("rnd_spurious", 64'(res_tag), 64'hFFFF);
        else begin
          e = exp_q.pop_front();
          chk("rnd_result", 64'({res_err, res_tag, res_data}), 64'(e));
        end
        n_res++;
      end
      chk("rnd_credit_range", 64'(dut.r_credits <= RES_DEPTH), 64'd1);
      hold_prev    = res_valid && !res_ready;
      prev_payload = 64'({res_err, res_tag, res_data});
      step();
      cyc++;
    end
    chk("rnd_accepted", 64'(n_acc), 64'd1000);
    chk("rnd_returned", 64'(n_res), 64'd1000);
    chk("rnd_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
